// File: rtl/i_cache.sv
// Direct-mapped, read-only instruction cache with synchronous-read arrays.
// Misses are filled from memory in ascending word order.
module i_cache #(
    parameter int INDEX_WIDTH  = 5,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [25:0] i_pc_next,
    input  logic [25:0] i_pc_current,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_miss_stall,
    output logic        mem_req_valid,
    output logic [25:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << OFFSET_WIDTH;
    localparam int IDX_LSB   = OFFSET_WIDTH + 2;
    localparam int TAG_LSB   = IDX_LSB + INDEX_WIDTH;
    localparam int TAG_WIDTH = 26 - TAG_LSB;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] REFILL = 2'd2;
    localparam logic [1:0] SETTLE = 2'd3;

    logic [1:0]              r_state;
    logic [25:0]             r_req_addr;
    logic [OFFSET_WIDTH-1:0] r_word_cnt;
    logic [LINES-1:0]        r_valid_bits;
    logic                    r_valid_rd;
    logic [TAG_WIDTH-1:0]    r_tag_rd;
    logic [TAG_WIDTH-1:0]    r_tag_mem [LINES];

    logic [INDEX_WIDTH-1:0]  w_rd_index;
    logic [INDEX_WIDTH-1:0]  w_fill_index;
    logic [TAG_WIDTH-1:0]    w_fill_tag;
    logic [TAG_WIDTH-1:0]    w_cur_tag;
    logic [OFFSET_WIDTH-1:0] w_cur_off;
    logic                    w_beat;
    logic                    w_last_beat;
    logic                    w_hit;
    logic [31:0]             w_rd_words [WORDS];

    // Outside IDLE the fetch PC is frozen, so the current PC drives the read.
    assign w_rd_index   = (r_state == IDLE) ? i_pc_next[TAG_LSB-1:IDX_LSB]
                                            : i_pc_current[TAG_LSB-1:IDX_LSB];
    assign w_fill_index = r_req_addr[TAG_LSB-1:IDX_LSB];
    assign w_fill_tag   = r_req_addr[25:TAG_LSB];
    assign w_cur_tag    = i_pc_current[25:TAG_LSB];
    assign w_cur_off    = i_pc_current[IDX_LSB-1:2];

    assign w_beat      = rst_n && (r_state == REFILL) && mem_resp_valid;
    assign w_last_beat = w_beat && (r_word_cnt == '1);
    assign w_hit       = (r_state == IDLE) && r_valid_rd && (r_tag_rd == w_cur_tag);

    assign o_valid       = w_hit;
    assign o_data        = w_rd_words[w_cur_off];
    assign o_miss_stall  = rst_n && !w_hit;
    assign mem_req_valid = rst_n && (r_state == REQ);
    assign mem_req_addr  = r_req_addr;

    // One word-wide bank per line offset; each bank takes the beat matching its offset.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_bank
            logic [31:0] r_mem [LINES];
            logic [31:0] r_rd_word;

            always_ff @(posedge clk) begin
                if (w_beat && (r_word_cnt == OFFSET_WIDTH'(gi))) begin
                    r_mem[w_fill_index] <= mem_resp_data;
                end
                r_rd_word <= r_mem[w_rd_index];
            end

            assign w_rd_words[gi] = r_rd_word;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_last_beat) begin
            r_tag_mem[w_fill_index] <= w_fill_tag;
        end
        r_tag_rd <= r_tag_mem[w_rd_index];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_req_addr   <= '0;
            r_word_cnt   <= '0;
            r_valid_bits <= '0;
            r_valid_rd   <= 1'b0;
        end else begin
            r_valid_rd <= r_valid_bits[w_rd_index];
            case (r_state)
                IDLE: begin
                    if (!w_hit) begin
                        r_state    <= REQ;
                        r_req_addr <= {i_pc_current[25:IDX_LSB], {IDX_LSB{1'b0}}};
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_state <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_resp_valid) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (r_word_cnt == '1) begin
                            r_valid_bits[w_fill_index] <= 1'b1;
                            r_state                    <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i_cache.sv
// Directed bench for i_cache: hand-computed line fills followed by
// table-driven hit/miss vectors.
module tb_i_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [25:0] i_pc_next;
    logic [25:0] i_pc_current;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_miss_stall;
    logic        mem_req_valid;
    logic [25:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [25:0] pc;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [20];

    i_cache #(.INDEX_WIDTH(5), .OFFSET_WIDTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pc_next     (i_pc_next),
        .i_pc_current  (i_pc_current),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_miss_stall  (o_miss_stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    // Miss on address a, then serve the line with words base+0..base+3.
    task automatic fill(input logic [25:0] a, input logic [31:0] base,
                        input int bp, input int gap);
        logic [25:0] la;
        int n;
        la = a & 26'h3FFFFF0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        i_pc_next      = a;
        cyc();
        i_pc_current = a;
        #1;
        n = 0;
        while (!mem_req_valid && n < 10) begin
            cyc();
            n++;
        end
        chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("req_addr", {6'd0, mem_req_addr}, {6'd0, la});
        for (int i = 0; i < bp; i++) begin
            chk("bp_hold", {29'd0, mem_req_valid, o_miss_stall, mem_req_addr == la}, 32'd7);
            cyc();
        end
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int g = 0; g < gap; g++) begin
                mem_resp_valid = 1'b0;
                mem_resp_data  = 32'hBAD0_0000;
                cyc();
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + 32'(w);
            cyc();
        end
        mem_resp_valid = 1'b0;
        chk("settle_stall", {30'd0, o_valid, o_miss_stall}, 32'd1);
        cyc();
        chk("fill_hit", {31'd0, o_valid}, 32'd1);
        chk("fill_data", o_data, base + 32'(a[3:2]));
    endtask

    // Fetch runs through tbl[s..e-1]; pc_next always leads pc_current by one cycle.
    task automatic run(input int s, input int e);
        i_pc_next = tbl[s].pc;
        cyc();
        for (int i = s; i < e; i++) begin
            i_pc_current = tbl[i].pc;
            i_pc_next    = (i + 1 < e) ? tbl[i + 1].pc : tbl[i].pc;
            #1;
            chk("vec_valid", {31'd0, o_valid}, {31'd0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) begin
                chk("vec_data", o_data, tbl[i].exp_data);
                chk("vec_noreq", {31'd0, mem_req_valid}, 32'd0);
            end
            cyc();
        end
    endtask

    initial begin
        tbl[0]  = '{26'h004, 1'b1, 32'hA1};
        tbl[1]  = '{26'h008, 1'b1, 32'hA2};
        tbl[2]  = '{26'h00C, 1'b1, 32'hA3};
        tbl[3]  = '{26'h010, 1'b1, 32'hB0};
        tbl[4]  = '{26'h01C, 1'b1, 32'hB3};
        tbl[5]  = '{26'h1F4, 1'b1, 32'hC1};
        tbl[6]  = '{26'h1FC, 1'b1, 32'hC3};
        tbl[7]  = '{26'h000, 1'b1, 32'hA0};
        tbl[8]  = '{26'h014, 1'b1, 32'hB1};
        tbl[9]  = '{26'h018, 1'b1, 32'hB2};
        tbl[10] = '{26'h1F8, 1'b1, 32'hC2};
        tbl[11] = '{26'h1F0, 1'b1, 32'hC0};
        tbl[12] = '{26'h204, 1'b1, 32'hD1};
        tbl[13] = '{26'h20C, 1'b1, 32'hD3};
        tbl[14] = '{26'h000, 1'b0, 32'h0};
        tbl[15] = '{26'h004, 1'b1, 32'hE1};
        tbl[16] = '{26'h008, 1'b1, 32'hE2};
        tbl[17] = '{26'h00C, 1'b1, 32'hE3};
        tbl[18] = '{26'h000, 1'b1, 32'hE0};
        tbl[19] = '{26'h1F0, 1'b1, 32'hC0};

        rst_n          = 1'b0;
        i_pc_next      = '0;
        i_pc_current   = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        cyc();
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("post_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("post_rst_stall", {31'd0, o_miss_stall}, 32'd1);

        fill(26'h000, 32'hA0, 0, 0);
        run(0, 3);
        fill(26'h010, 32'hB0, 0, 2);
        fill(26'h1F0, 32'hC0, 5, 0);
        run(3, 12);
        fill(26'h200, 32'hD0, 0, 0);
        run(12, 15);

        // Now in REQ for line 0x0: accept, deliver two beats, then reset.
        #1;
        chk("conflict_req", {31'd0, mem_req_valid}, 32'd1);
        chk("conflict_addr", {6'd0, mem_req_addr}, 32'd0);
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h11;
        cyc();
        mem_resp_data = 32'h22;
        cyc();
        mem_resp_valid = 1'b0;
        rst_n          = 1'b0;
        #1;
        chk("midfill_rst_req", {31'd0, mem_req_valid}, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("abandon_valid", {31'd0, o_valid}, 32'd0);
        chk("abandon_idle", {31'd0, mem_req_valid}, 32'd0);
        cyc();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            chk("stray_req", {31'd0, mem_req_valid}, 32'd1);
            chk("stray_valid", {31'd0, o_valid}, 32'd0);
            cyc();
        end
        mem_resp_valid = 1'b0;
        fill(26'h000, 32'hE0, 0, 1);
        run(15, 19);
        // Reset also cleared the index-31 line, so it must miss now.
        fill(26'h1F0, 32'hC0, 0, 0);
        run(19, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
